// File: rtl/fifo_stream_drain_pkg.sv
// Shared constants and types for the FIFO read-side stream drain.
// The default word width must track the Synchronous_FIFO it sits behind.
package fifo_stream_drain_pkg;

    localparam int FIFO_DATA_WIDTH = 32;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry in-order holding buffer: slot0 is always the head, slot1 the tail.
// Pure storage; the caller guarantees it never pushes into a full buffer.
module fifo_skid_buf2
    import fifo_stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            cnt,
    output logic [DATA_WIDTH-1:0] head
);

    occ_t                  cnt_q;
    logic [DATA_WIDTH-1:0] slot0_q;
    logic [DATA_WIDTH-1:0] slot1_q;

    assign cnt  = cnt_q;
    assign head = slot0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else if (clr) begin
            cnt_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) slot0_q <= push_data;
                    else               slot1_q <= push_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    cnt_q   <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the head advances and the new word lands behind it.
                    if (cnt_q == 2'd2) begin
                        slot0_q <= slot1_q;
                        slot1_q <= push_data;
                    end else begin
                        slot0_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a Synchronous_FIFO (1-cycle registered read) into a valid/ready stream.
// Reads are issued only when the skid buffer is guaranteed a slot for the returning word.
module fifo_stream_drain
    import fifo_stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_out
);

    logic [1:0] cnt;
    logic       inflight_q;
    logic       pop;
    logic       push;
    logic [2:0] committed;

    assign m_valid = (cnt != 2'd0);
    assign pop     = m_valid && m_ready;
    // A word returning during a flush belongs to the dropped stream.
    assign push    = inflight_q && !flush;

    // Slots that will still be claimed after this edge's pop, counting the word in flight.
    assign committed  = {1'b0, cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = !rst && !flush && !fifo_empty && (committed < 3'd2);
    assign fifo_cs    = !rst;

    fifo_skid_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (push),
        .push_data(fifo_data_out),
        .pop      (pop),
        .cnt      (cnt),
        .head     (m_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            words_out  <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (pop) words_out <= words_out + 1'b1;
        end
    end

endmodule
